// File: rtl/serial_disp_arbiter.sv
// Arbitrates one shared serial shift chain between a 16-bit LED word and a 64-bit 7-segment word.
// Ports: clk, rst (sync, active high); led_we/led_in, seg_we/seg_in write strobes;
// sclk, sdat, led_pen, seg_pen, busy, grant are registered outputs.
module serial_disp_arbiter #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_we,
  input  logic [15:0] led_in,
  input  logic        seg_we,
  input  logic [63:0] seg_in,
  output logic        sclk,
  output logic        sdat,
  output logic        led_pen,
  output logic        seg_pen,
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH
  } state_e;

  localparam logic [7:0]  DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [31:0] REF_M1 =
    (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;

  state_e      state_q, state_d;
  logic [15:0] led_sh_q, led_sh_d;
  logic [63:0] seg_sh_q, seg_sh_d;
  logic [1:0]  pend_q, pend_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic [63:0] sh_q, sh_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic [31:0] ref_q, ref_d;

  logic        sclk_q, sclk_d;
  logic        sdat_q, sdat_d;
  logic        lpen_q, lpen_d;
  logic        spen_q, spen_d;
  logic        busy_q, busy_d;
  logic [1:0]  grant_q, grant_d;

  logic        phase_end;
  logic        ref_hit;
  logic [1:0]  pend_eff;
  logic [1:0]  clr;

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      led_sh_q <= '0;
      seg_sh_q <= '0;
      pend_q   <= 2'b11;
      last_q   <= 1'b0;
      sel_q    <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      ref_q    <= '0;
      sclk_q   <= 1'b0;
      sdat_q   <= 1'b0;
      lpen_q   <= 1'b0;
      spen_q   <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      led_sh_q <= led_sh_d;
      seg_sh_q <= seg_sh_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ref_q    <= ref_d;
      sclk_q   <= sclk_d;
      sdat_q   <= sdat_d;
      lpen_q   <= lpen_d;
      spen_q   <= spen_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
    end
  end

  // next-state logic; bit 0 = LED, bit 1 = SEG; sel/last: 1 = SEG
  always_comb begin
    phase_end = (div_q == DIV_M1);
    ref_hit   = (REFRESH_CYCLES != 0) && (ref_q == REF_M1);
    // a strobe in the IDLE cycle starts the frame without waiting a cycle
    pend_eff  = pend_q | {seg_we, led_we};
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    div_d     = phase_end ? 8'd0 : div_q + 8'd1;
    clr       = 2'b00;
    unique case (state_q)
      IDLE: begin
        div_d = 8'd0;
        if (|pend_eff) begin
          state_d = LOAD;
          if (pend_eff == 2'b11) sel_d = ~last_q;
          else                   sel_d = pend_eff[1];
        end
      end
      LOAD: begin
        div_d   = 8'd0;
        sh_d    = sel_q ? seg_sh_q : {led_sh_q, 48'h0};
        cnt_d   = sel_q ? 7'd64 : 7'd16;
        clr     = sel_q ? 2'b10 : 2'b01;
        last_d  = sel_q;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_end) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          sh_d    = {sh_q[62:0], 1'b0};
          cnt_d   = cnt_q - 7'd1;
          state_d = (cnt_q == 7'd1) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // set wins over the LOAD-cycle clear so a colliding write is re-sent
    pend_d   = (pend_q & ~clr) | {seg_we, led_we} | {2{ref_hit}};
    led_sh_d = led_we ? led_in : led_sh_q;
    seg_sh_d = seg_we ? seg_in : seg_sh_q;
    ref_d    = (REFRESH_CYCLES == 0 || ref_hit) ? 32'd0 : ref_q + 32'd1;
  end

  // outputs are decoded from the next state so they line up with state_q
  always_comb begin
    sclk_d  = (state_d == SHIFT_HI);
    sdat_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? sh_d[63] : 1'b0;
    busy_d  = (state_d != IDLE);
    grant_d = busy_d ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
    lpen_d  = (state_d == LATCH) && !sel_d;
    spen_d  = (state_d == LATCH) && sel_d;
  end

  assign sclk    = sclk_q;
  assign sdat    = sdat_q;
  assign led_pen = lpen_q;
  assign seg_pen = spen_q;
  assign busy    = busy_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_serial_disp_arbiter.sv
// Scoreboard bench for serial_disp_arbiter: captured frames are matched
// against expected frames queued at stimulus time.
module tb_serial_disp_arbiter;

  typedef struct {
    bit          seg;
    int          nbits;
    logic [63:0] data;
    int          pen;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        led_we = 1'b0;
  logic [15:0] led_in = '0;
  logic        seg_we = 1'b0;
  logic [63:0] seg_in = '0;
  logic        sclk, sdat, led_pen, seg_pen, busy;
  logic [1:0]  grant;

  logic        r_led_we = 1'b0;
  logic [15:0] r_led_in = '0;
  logic        r_seg_we = 1'b0;
  logic [63:0] r_seg_in = '0;
  logic        r_sclk, r_sdat, r_led_pen, r_seg_pen, r_busy;
  logic [1:0]  r_grant;

  int checks = 0;
  int failures = 0;

  frame_t expq[$];
  frame_t obsq[$];
  logic [1:0] glog[$];
  int busyq[$];
  int viol = 0;

  logic [63:0] acc0;
  int nb0, pl0, bl0;
  logic sclk_p, lp_p, sp_p;
  logic [1:0] g_p;

  logic [15:0] r_led_val = '0;
  logic [63:0] r_seg_val = '0;
  int r_led_n = 0, r_seg_n = 0, r_bad = 0, r_ovl = 0;
  logic [63:0] acc1;
  int nb1;
  logic s1_p, l1p, s1p;

  always #5 clk = ~clk;

  serial_disp_arbiter #(.CLK_DIV(2), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .led_we(led_we), .led_in(led_in),
    .seg_we(seg_we), .seg_in(seg_in),
    .sclk(sclk), .sdat(sdat),
    .led_pen(led_pen), .seg_pen(seg_pen),
    .busy(busy), .grant(grant)
  );

  serial_disp_arbiter #(.CLK_DIV(1), .REFRESH_CYCLES(200)) dut_r (
    .clk(clk), .rst(rst),
    .led_we(r_led_we), .led_in(r_led_in),
    .seg_we(r_seg_we), .seg_in(r_seg_in),
    .sclk(r_sclk), .sdat(r_sdat),
    .led_pen(r_led_pen), .seg_pen(r_seg_pen),
    .busy(r_busy), .grant(r_grant)
  );

  always @(negedge clk) begin
    frame_t f;
    if (rst) begin
      acc0 = '0; nb0 = 0; pl0 = 0; bl0 = 0;
      sclk_p = 1'b0; lp_p = 1'b0; sp_p = 1'b0; g_p = 2'b00;
    end else begin
      if (sclk && !sclk_p) begin
        acc0 = {acc0[62:0], sdat};
        nb0++;
      end
      if (led_pen && seg_pen) viol++;
      if (led_pen && grant !== 2'b01) viol++;
      if (seg_pen && grant !== 2'b10) viol++;
      if (led_pen || seg_pen) pl0++;
      else if (lp_p || sp_p) begin
        f.seg = sp_p; f.nbits = nb0; f.data = acc0; f.pen = pl0;
        obsq.push_back(f);
        acc0 = '0; nb0 = 0; pl0 = 0;
      end
      if (busy) bl0++;
      else if (bl0 != 0) begin
        busyq.push_back(bl0);
        bl0 = 0;
      end
      if (grant !== g_p) glog.push_back(grant);
      sclk_p = sclk; lp_p = led_pen; sp_p = seg_pen; g_p = grant;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      acc1 = '0; nb1 = 0; s1_p = 1'b0; l1p = 1'b0; s1p = 1'b0;
    end else begin
      if (r_sclk && !s1_p) begin
        acc1 = {acc1[62:0], r_sdat};
        nb1++;
      end
      if (r_led_pen && r_seg_pen) r_ovl++;
      if (r_led_pen && r_grant !== 2'b01) r_ovl++;
      if (r_seg_pen && r_grant !== 2'b10) r_ovl++;
      if ((r_led_pen || r_seg_pen) && !r_busy) r_ovl++;
      if (!r_led_pen && !r_seg_pen && (l1p || s1p)) begin
        if (s1p) begin
          r_seg_n++;
          if (nb1 != 64 || acc1 !== r_seg_val) r_bad++;
        end else begin
          r_led_n++;
          if (nb1 != 16 || acc1 !== {48'h0, r_led_val}) r_bad++;
        end
        acc1 = '0; nb1 = 0;
      end
      s1_p = r_sclk; l1p = r_led_pen; s1p = r_seg_pen;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_frame(input bit seg, input logic [63:0] d);
    frame_t e;
    e.seg = seg; e.nbits = seg ? 64 : 16; e.data = d; e.pen = 2;
    expq.push_back(e);
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int t = 0;
    while (obsq.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    ok = (obsq.size() >= n);
    cyc(3);
  endtask

  task automatic test_reset;
    bit ok;
    frame_t e, o;
    rst = 1'b1;
    cyc(3);
    @(negedge clk);
    checks++;
    if ({sclk, sdat, led_pen, seg_pen, busy, grant} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {sclk, sdat, led_pen, seg_pen, busy, grant});
    end
    obsq.delete(); glog.delete(); busyq.delete(); expq.delete();
    exp_frame(1'b1, 64'h0);
    exp_frame(1'b0, 64'h0);
    cyc(1);
    rst = 1'b0;
    wait_obs(expq.size(), ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_frames_timeout got=%0d want=%0d", obsq.size(), expq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL reset_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    checks++;
    if (glog.size() != 4 || glog[0] !== 2'b10 || glog[1] !== 2'b00 ||
        glog[2] !== 2'b01 || glog[3] !== 2'b00) begin
      failures++;
      $display("FAIL reset_grant_seq got=%p want=10,00,01,00", glog);
    end
    expq.delete();
  endtask

  task automatic test_led_single;
    bit ok;
    frame_t e, o;
    busyq.delete();
    exp_frame(1'b0, 64'h0000_0000_0000_A5C3);
    led_in = 16'hA5C3; led_we = 1'b1;
    cyc(1);
    led_we = 1'b0;
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL led_single_timeout got=%0d want=1", obsq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL led_single_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    checks++;
    if (busyq.size() != 1 || busyq[0] != 67) begin
      failures++;
      $display("FAIL led_busy_len got=%p want=67", busyq);
    end
    expq.delete();
  endtask

  task automatic test_load_collision;
    bit ok;
    frame_t e, o;
    exp_frame(1'b0, 64'h0000_0000_0000_AAAA);
    exp_frame(1'b0, 64'h0000_0000_0000_5555);
    led_in = 16'hAAAA; led_we = 1'b1;
    cyc(1);
    led_in = 16'h5555;
    cyc(1);
    led_we = 1'b0;
    wait_obs(expq.size(), ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL collision_timeout got=%0d want=%0d", obsq.size(), expq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL collision_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    expq.delete();
  endtask

  task automatic test_simultaneous;
    bit ok;
    frame_t e, o;
    glog.delete();
    exp_frame(1'b1, 64'h0123_4567_89AB_CDEF);
    exp_frame(1'b0, 64'h0000_0000_0000_1234);
    led_in = 16'h1234; seg_in = 64'h0123_4567_89AB_CDEF;
    led_we = 1'b1; seg_we = 1'b1;
    cyc(1);
    led_we = 1'b0; seg_we = 1'b0;
    wait_obs(expq.size(), ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL simul_timeout got=%0d want=%0d", obsq.size(), expq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL simul_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    checks++;
    if (glog.size() != 4 || glog[0] !== 2'b10 || glog[1] !== 2'b00 ||
        glog[2] !== 2'b01 || glog[3] !== 2'b00) begin
      failures++;
      $display("FAIL simul_grant_seq got=%p want=10,00,01,00", glog);
    end
    expq.delete();
  endtask

  task automatic test_merge;
    bit ok;
    frame_t e, o;
    exp_frame(1'b0, 64'h0000_0000_0000_1111);
    exp_frame(1'b0, 64'h0000_0000_0000_3333);
    led_in = 16'h1111; led_we = 1'b1;
    cyc(1);
    led_we = 1'b0;
    cyc(15);
    led_in = 16'h2222; led_we = 1'b1;
    cyc(1);
    led_we = 1'b0;
    cyc(15);
    led_in = 16'h3333; led_we = 1'b1;
    cyc(1);
    led_we = 1'b0;
    wait_obs(expq.size(), ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL merge_timeout got=%0d want=%0d", obsq.size(), expq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL merge_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    cyc(150);
    checks++;
    if (obsq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL merge_extra_frames got=%0d busy=%b want=0 busy=0", obsq.size(), busy);
    end
    expq.delete(); obsq.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    int t = 0;
    frame_t e, o;
    seg_in = 64'hFFFF_0000_AAAA_5555; seg_we = 1'b1;
    cyc(1);
    seg_we = 1'b0;
    while (nb0 < 30 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (nb0 < 30) begin
      failures++;
      $display("FAIL mid_reach_bit30 got=%0d want=30", nb0);
    end
    cyc(1);
    rst = 1'b1;
    led_we = 1'b1; led_in = 16'hFFFF;
    cyc(1);
    rst = 1'b0; led_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({sclk, sdat, led_pen, seg_pen, busy, grant} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b want=0000000",
               {sclk, sdat, led_pen, seg_pen, busy, grant});
    end
    obsq.delete();
    exp_frame(1'b1, 64'h0);
    exp_frame(1'b0, 64'h0);
    wait_obs(expq.size(), ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_timeout got=%0d want=%0d", obsq.size(), expq.size());
    end
    while (expq.size() > 0 && obsq.size() > 0) begin
      e = expq.pop_front(); o = obsq.pop_front();
      checks++;
      if (o.seg !== e.seg || o.nbits != e.nbits || o.data !== e.data || o.pen != e.pen) begin
        failures++;
        $display("FAIL mid_frame got=%0d/%0d/%h/%0d want=%0d/%0d/%h/%0d",
                 o.seg, o.nbits, o.data, o.pen, e.seg, e.nbits, e.data, e.pen);
      end
    end
    expq.delete();
  endtask

  task automatic test_refresh;
    int l0, s0, b0;
    r_led_in = 16'hBEEF; r_seg_in = 64'hDEAD_BEEF_0BAD_F00D;
    r_led_we = 1'b1; r_seg_we = 1'b1;
    r_led_val = 16'hBEEF; r_seg_val = 64'hDEAD_BEEF_0BAD_F00D;
    cyc(1);
    r_led_we = 1'b0; r_seg_we = 1'b0;
    cyc(400);
    l0 = r_led_n; s0 = r_seg_n; b0 = r_bad;
    cyc(1000);
    checks++;
    if (r_led_n - l0 < 4 || r_led_n - l0 > 6) begin
      failures++;
      $display("FAIL refresh_led_count got=%0d want=4..6", r_led_n - l0);
    end
    checks++;
    if (r_seg_n - s0 < 4 || r_seg_n - s0 > 6) begin
      failures++;
      $display("FAIL refresh_seg_count got=%0d want=4..6", r_seg_n - s0);
    end
    checks++;
    if (r_bad != b0) begin
      failures++;
      $display("FAIL refresh_data got=%0d bad frames want=0", r_bad - b0);
    end
    checks++;
    if (r_ovl != 0 || viol != 0) begin
      failures++;
      $display("FAIL pen_violations got=%0d/%0d want=0/0", r_ovl, viol);
    end
  endtask

  initial begin
    test_reset();
    test_led_single();
    test_load_collision();
    test_simultaneous();
    test_merge();
    test_reset_mid();
    test_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_disp_arbiter.md
SERIAL_DISP_ARBITER -- requirements
Module: serial_disp_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 2: sclk half-period in clk cycles, legal range 1..255.
REQ-002 Parameter REFRESH_CYCLES, default 0: periodic re-send interval in clk cycles; 0 disables periodic re-send.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 led_we  input  1  one-cycle write strobe for the LED word.
REQ-006 led_in  input  16  LED word, sampled when led_we=1.
REQ-007 seg_we  input  1  one-cycle write strobe for the 7-segment word.
REQ-008 seg_in  input  64  7-segment word, sampled when seg_we=1.
REQ-009 sclk  output  1  shared serial clock to both shift chains.
REQ-010 sdat  output  1  shared serial data, MSB first.
REQ-011 led_pen  output  1  LED chain latch pulse, active high.
REQ-012 seg_pen  output  1  7-segment chain latch pulse, active high.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 grant  output  2  one-hot owner of the shift chain: 01=LED, 10=SEG, 00=none.

Function
REQ-015 Shadow registers: led_sh<=led_in on led_we and seg_sh<=seg_in on seg_we, in every FSM state, effective the next cycle.
REQ-016 Each write strobe sets its channel's pending flag; the flag clears only in that channel's LOAD cycle.
REQ-017 FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
REQ-018 IDLE: if any flag is pending, select a channel and go to LOAD next cycle; otherwise stay in IDLE.
REQ-019 Arbitration: one pending channel wins outright; if both are pending, the channel not served last wins (round-robin); after reset, LED counts as served last, so SEG wins first.
REQ-020 LOAD, 1 cycle: copy the winner's shadow into the shift register; set the bit counter to 16 (LED) or 64 (SEG); clear the winner's pending flag; set grant; go to SHIFT_LO.
REQ-021 SHIFT_LO, CLK_DIV cycles: sclk=0; sdat=current MSB of the shift register, stable for the whole phase; then go to SHIFT_HI.
REQ-022 SHIFT_HI, CLK_DIV cycles: sclk=1; on exit, shift left by 1 and decrement the counter; counter 0 goes to LATCH, else SHIFT_LO.
REQ-023 LATCH, CLK_DIV cycles: sclk=0, sdat=0, the granted channel's pen=1, the other pen=0; then go to IDLE and set grant=00.
REQ-024 The pen of the non-granted channel stays 0 in every state.
REQ-025 Frame length from the strobe cycle to return to IDLE is 1+1+2*N*CLK_DIV+CLK_DIV cycles (N=16 or 64); LED at CLK_DIV=2 is 68 cycles.
REQ-026 A write to the channel currently shifting does not disturb the frame in flight; it sets pending, so the channel is re-sent with the new data.
REQ-027 Multiple writes to one channel while it is pending merge into one frame carrying the last written value.
REQ-028 Simultaneous led_we and seg_we: both flags are set; frames follow back-to-back under REQ-019, with one IDLE cycle between them.
REQ-029 Write strobe in the same cycle as LOAD for that channel: the new value is not in the current frame, and pending stays set.
REQ-030 Refresh counter, REFRESH_CYCLES>0: counts every clk; at REFRESH_CYCLES-1 it wraps to 0 and sets both pending flags.
REQ-031 sclk, sdat, led_pen, seg_pen, busy and grant are registered outputs with no combinational path from inputs.

Reset
REQ-032 rst=1 for one or more cycles: FSM=IDLE, sclk=0, sdat=0, led_pen=0, seg_pen=0, busy=0, grant=00, counters=0, shadows=0.
REQ-033 Reset sets both pending flags, so both chains are cleared with all-zero frames after reset.
REQ-034 Reset mid-frame aborts the frame at once; no pen pulse is issued for the aborted frame.
REQ-035 rst has priority over led_we and seg_we in the same cycle.

Verification
REQ-036 Reset release, no writes -> SEG 64-bit zero frame, then LED 16-bit zero frame; each ends with a CLK_DIV-cycle pen pulse on its own chain.
REQ-037 led_we with led_in=16'hA5C3 while idle -> the 16 bits captured on sclk rising edges, MSB first, equal A5C3; then led_pen high for 2 cycles; busy high for 67 cycles.
REQ-038 led_we and seg_we in the same cycle, with LED served last -> SEG frame first, then LED frame; grant sequence 10, 00, 01, 00.
REQ-039 led_we=16'h1111 during an LED frame, then 16'h2222 and 16'h3333 before it ends -> frame in flight is unchanged; exactly one follow-up LED frame, carrying 3333.
REQ-040 rst asserted at bit 30 of a SEG frame -> next cycle all outputs at reset values; no seg_pen pulse; zero frames follow per REQ-033.
REQ-041 REFRESH_CYCLES=200, no writes, 1000 cycles -> both chains re-sent each period with the last shadow values; pen pulses never overlap.
